// File: rtl/spi_reg_responder_if.sv
// Pin and fabric-side bundle for spi_reg_responder: SPI link, host register port
// and the per-byte SPI write notification.
interface spi_reg_responder_if;
  logic       spi_SCLK;
  logic       spi_SS_n;
  logic       spi_MOSI;
  logic       spi_MISO;
  logic       spi_MISO_oe;
  logic [4:0] host_addr;
  logic       host_wr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       spi_wr_valid;
  logic [4:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       busy;

  modport slave (
    input  spi_SCLK, spi_SS_n, spi_MOSI, host_addr, host_wr, host_wdata,
    output spi_MISO, spi_MISO_oe, host_rdata, spi_wr_valid, spi_wr_addr,
           spi_wr_data, busy
  );

  modport master (
    output spi_SCLK, spi_SS_n, spi_MOSI, host_addr, host_wr, host_wdata,
    input  spi_MISO, spi_MISO_oe, host_rdata, spi_wr_valid, spi_wr_addr,
           spi_wr_data, busy
  );
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave in front of a 32 x 8 register file, MAX3421E-style command byte
// with auto-increment; a second fabric port shares the same registers.
module spi_reg_responder #(
  parameter logic [4:0] STATUS_ADDR = 5'd0,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input logic                clk_50_clk,
  input logic                reset_50_reset_n,
  spi_reg_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_q, ssn_q;
  logic [1:0] mosi_q;
  logic [7:0] mem_q [32];
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       busy_q, busy_d;
  logic [4:0] addr_q, addr_d;
  logic       wr_valid_q, wr_valid_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] host_rdata_q;

  logic       sclk_rise, sclk_fall, ssn_fall, ssn_rise;
  logic [7:0] rx_byte;
  logic [4:0] addr_inc;
  logic       spi_we;

  // Two synchronizer flops per pin; the third SCLK/SS_n flop gives edge detection.
  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) begin
      sclk_q <= 3'b000;
      ssn_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_SCLK};
      ssn_q  <= {ssn_q[1:0], bus.spi_SS_n};
      mosi_q <= {mosi_q[0], bus.spi_MOSI};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ssn_fall  = ~ssn_q[1] & ssn_q[2];
  assign ssn_rise  = ssn_q[1] & ~ssn_q[2];
  assign rx_byte   = {rx_q, mosi_q[1]};
  assign addr_inc  = addr_q + 5'd1;

  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'd0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= 5'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // miso_q holds the bit on the wire; tx_q holds the bits still to come, so a
  // byte loaded at a boundary puts its bit7 out on the following SCLK fall.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    spi_we     = 1'b0;
    if (state_q == IDLE) begin
      if (ssn_fall) begin
        state_d  = CMD;
        bitcnt_d = 3'd0;
        rx_d     = 7'd0;
        miso_d   = mem_q[STATUS_ADDR][7];
        tx_d     = {mem_q[STATUS_ADDR][6:0], 1'b0};
        busy_d   = 1'b1;
      end
    end else if (ssn_rise) begin
      state_d  = IDLE;
      bitcnt_d = 3'd0;
      busy_d   = 1'b0;
      miso_d   = 1'b0;
      tx_d     = 8'd0;
    end else if (sclk_rise) begin
      rx_d     = rx_byte[6:0];
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        case (state_q)
          CMD: begin
            addr_d = rx_byte[7:3];
            if (rx_byte[1]) begin
              state_d = WR;
              tx_d    = 8'd0;
            end else begin
              state_d = RD;
              tx_d    = mem_q[rx_byte[7:3]];
            end
          end
          WR: begin
            spi_we     = 1'b1;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = rx_byte;
            addr_d     = addr_inc;
            tx_d       = 8'd0;
          end
          RD: begin
            addr_d = addr_inc;
            tx_d   = mem_q[addr_inc];
          end
          default: ;
        endcase
      end
    end else if (sclk_fall) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
  end

  // SPI write is issued after the host write so it wins a same-register collision.
  always_ff @(posedge clk_50_clk or negedge reset_50_reset_n) begin
    if (!reset_50_reset_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= RESET_VAL;
      host_rdata_q <= 8'd0;
    end else begin
      host_rdata_q <= mem_q[bus.host_addr];
      if (bus.host_wr) mem_q[bus.host_addr] <= bus.host_wdata;
      if (spi_we) mem_q[addr_q] <= rx_byte;
    end
  end

  assign bus.spi_MISO     = busy_q & miso_q;
  assign bus.spi_MISO_oe  = busy_q;
  assign bus.busy         = busy_q;
  assign bus.host_rdata   = host_rdata_q;
  assign bus.spi_wr_valid = wr_valid_q;
  assign bus.spi_wr_addr  = wr_addr_q;
  assign bus.spi_wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed plus randomized bench for spi_reg_responder against a transaction-level
// register-file model.
module tb_spi_reg_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_reg_responder_if bus();

  spi_reg_responder dut (
    .clk_50_clk      (clk),
    .reset_50_reset_n(rst_n),
    .bus             (bus)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mdl [32];
  logic [7:0]  txq [$];
  logic [7:0]  miso_got [$];
  logic [12:0] wr_log [$];
  logic [4:0]  coll_addr;
  logic [7:0]  coll_data;

  always @(negedge clk)
    if (rst_n && bus.spi_wr_valid === 1'b1)
      wr_log.push_back({bus.spi_wr_addr, bus.spi_wr_data});

  initial begin
    #10ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.host_addr = a; bus.host_wdata = d; bus.host_wr = 1'b1;
    @(negedge clk);
    bus.host_wr = 1'b0;
    mdl[a] = d;
  endtask

  task automatic host_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.host_addr = a;
    @(negedge clk);
    check(tag, 32'(bus.host_rdata), 32'(exp));
  endtask

  task automatic spi_bit(input logic b, input bit coll, output logic m);
    bus.spi_MOSI = b;
    repeat (5) @(negedge clk);
    m = bus.spi_MISO;
    bus.spi_SCLK = 1'b1;
    if (coll) begin
      repeat (2) @(negedge clk);
      bus.host_addr = coll_addr; bus.host_wdata = coll_data; bus.host_wr = 1'b1;
      @(negedge clk);
      bus.host_wr = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    bus.spi_SCLK = 1'b0;
  endtask

  task automatic spi_txn(input int partial, input bit collide, input string tag);
    logic [7:0] rxb;
    logic       m;
    int         nbytes;
    miso_got.delete();
    rxb = 8'd0;
    bus.spi_SS_n = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    check({tag, "_oe_on"}, 32'(bus.spi_MISO_oe), 32'd1);
    nbytes = txq.size() + ((partial > 0) ? 1 : 0);
    for (int b = 0; b < nbytes; b++) begin
      int         nb;
      logic [7:0] v;
      nb = (b < txq.size()) ? 8 : partial;
      v  = (b < txq.size()) ? txq[b] : 8'hFF;
      for (int i = 7; i >= 8 - nb; i--) begin
        spi_bit(v[i], collide && (b == txq.size() - 1) && (i == 0), m);
        rxb = {rxb[6:0], m};
      end
      if (nb == 8) miso_got.push_back(rxb);
    end
    repeat (5) @(negedge clk);
    bus.spi_SS_n = 1'b1;
    repeat (6) @(negedge clk);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_oe_off"}, 32'(bus.spi_MISO_oe), 32'd0);
  endtask

  // Transaction-level expectations from the command byte, then drive and compare.
  task automatic run_txn(input int partial, input bit collide, input string tag);
    logic [7:0]  exp_miso [$];
    logic [12:0] exp_wr [$];
    logic [7:0]  cmd;
    logic [4:0]  a;
    cmd = txq[0];
    a = cmd[7:3];
    exp_miso.push_back(mdl[0]);
    if (collide) mdl[coll_addr] = coll_data;
    for (int k = 1; k < txq.size(); k++) begin
      if (cmd[1]) begin
        exp_miso.push_back(8'h00);
        mdl[a] = txq[k];
        exp_wr.push_back({a, txq[k]});
      end else begin
        exp_miso.push_back(mdl[a]);
      end
      a = a + 5'd1;
    end
    wr_log.delete();
    spi_txn(partial, collide, tag);
    check({tag, "_miso_cnt"}, 32'(miso_got.size()), 32'(exp_miso.size()));
    for (int k = 0; k < exp_miso.size() && k < miso_got.size(); k++)
      check($sformatf("%s_miso%0d", tag, k), 32'(miso_got[k]), 32'(exp_miso[k]));
    check({tag, "_wr_cnt"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      check($sformatf("%s_wr%0d", tag, k), 32'(wr_log[k]), 32'(exp_wr[k]));
  endtask

  initial begin
    logic m;
    bus.spi_SCLK = 1'b0; bus.spi_SS_n = 1'b1; bus.spi_MOSI = 1'b0;
    bus.host_addr = 5'd0; bus.host_wr = 1'b0; bus.host_wdata = 8'd0;
    coll_addr = 5'd0; coll_data = 8'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_oe", 32'(bus.spi_MISO_oe), 32'd0);
    check("rst_miso", 32'(bus.spi_MISO), 32'd0);
    rst_n = 1'b1;

    // 1: reset state
    host_read(5'd5, 8'h00, "t1_reg5");
    check("t1_busy", 32'(bus.busy), 32'd0);
    check("t1_oe", 32'(bus.spi_MISO_oe), 32'd0);
    check("t1_wrv", 32'(bus.spi_wr_valid), 32'd0);
    check("t1_wrlog", 32'(wr_log.size()), 32'd0);

    // 2: write burst with auto-increment
    txq = {8'h2A, 8'hA5, 8'h3C};
    run_txn(0, 1'b0, "t2");
    check("t2_wr0_const", 32'(wr_log.size() > 0 ? wr_log[0] : 13'h0), 32'({5'd5, 8'hA5}));
    host_read(5'd5, 8'hA5, "t2_reg5");
    host_read(5'd6, 8'h3C, "t2_reg6");

    // 3: read with address wrap
    host_write(5'd0, 8'h42);
    host_write(5'd31, 8'h81);
    txq = {8'hF8, 8'h00, 8'h00};
    run_txn(0, 1'b0, "t3");
    check("t3_b2_const", 32'(miso_got.size() > 2 ? miso_got[2] : 8'h0), 32'h42);

    // 4: partial byte discarded
    txq = {8'h12};
    run_txn(4, 1'b0, "t4a");
    host_read(5'd2, 8'h00, "t4_reg2_kept");
    txq = {8'h12, 8'h77};
    run_txn(0, 1'b0, "t4b");
    host_read(5'd2, 8'h77, "t4_reg2");

    // 5: same-cycle collision, SPI wins
    coll_addr = 5'd7; coll_data = 8'hAA;
    txq = {8'h3A, 8'h55};
    run_txn(0, 1'b1, "t5");
    host_read(5'd7, 8'h55, "t5_reg7");

    // 6: reset mid-byte during a read
    bus.spi_SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(txq[0][0] ^ txq[0][0] ^ 1'((8'h28 >> i) & 8'h01), 1'b0, m);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b0, m);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_oe", 32'(bus.spi_MISO_oe), 32'd0);
    check("t6_miso", 32'(bus.spi_MISO), 32'd0);
    check("t6_wrv", 32'(bus.spi_wr_valid), 32'd0);
    check("t6_rdata", 32'(bus.host_rdata), 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.spi_SS_n = 1'b1;
    repeat (8) @(negedge clk);
    host_read(5'd7, 8'h00, "t6_reg7");
    txq = {8'h28, 8'h00};
    run_txn(0, 1'b0, "t6");
    check("t6_reg5_const", 32'(miso_got.size() > 1 ? miso_got[1] : 8'hFF), 32'h00);

    // Randomized transactions against the model
    for (int n = 0; n < 24; n++) begin
      int         nd;
      int         part;
      logic [4:0] ra;
      if ($urandom_range(0, 1) == 1) host_write(5'($urandom), 8'($urandom));
      txq = {};
      txq.push_back(8'($urandom));
      nd = $urandom_range(0, 3);
      for (int k = 0; k < nd; k++) txq.push_back(8'($urandom));
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_txn(part, 1'b0, $sformatf("r%0d", n));
      ra = 5'($urandom);
      host_read(ra, mdl[ra], $sformatf("r%0d_host", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
SPI mode-0 slave and the far end of the SoC's spi0 master link (SCLK, MOSI, SS_n in; MISO out).
- Protocol is MAX3421E-style: a command byte carries a 5-bit register address and a direction bit; the following bytes read or write a 32 x 8 register file, with auto-increment.
- Fabric logic owns a second port into the same register file.
- Used for loopback bring-up of the NIOS SPI driver without the USB chip.

Parameters:
STATUS_ADDR, 0, register whose value is shifted out on MISO during the command byte.
RESET_VAL, 8'h00, reset value of all 32 registers.

Ports:
clk_50_clk  in  1  system clock, 50 MHz.
reset_50_reset_n  in  1  asynchronous active-low reset.
spi_SCLK  in  1  SPI clock from master, asynchronous to clk.
spi_SS_n  in  1  slave select, active low, asynchronous.
spi_MOSI  in  1  master data, asynchronous.
spi_MISO  out  1  slave data, MSB first.
spi_MISO_oe  out  1  MISO drive enable, high while selected.
host_addr  in  5  fabric register address.
host_wr  in  1  fabric write strobe, single cycle.
host_wdata  in  8  fabric write data.
host_rdata  out  8  register[host_addr], registered, 1-cycle latency.
spi_wr_valid  out  1  one-cycle pulse per completed SPI write byte.
spi_wr_addr  out  5  address of that write.
spi_wr_data  out  8  data of that write.
busy  out  1  high while a transaction is active (SS_n low, synchronized).

Behaviour:
- **Clock and reset:** one clock (clk_50_clk). reset_50_reset_n is asynchronous, active-low.
- **Reset values:**
  - All outputs 0; spi_MISO_oe 0.
  - All registers RESET_VAL; FSM in IDLE; shift and bit counters 0.
- **Synchronization:**
  - SCLK, SS_n and MOSI each pass through 2 flops.
  - SCLK rise and fall, and SS_n fall and rise, are detected by a third flop.
  - Event latency is 3 clk after the pin edge.
  - Supported SCLK: high and low phases each >= 4 clk (SCLK <= 6.25 MHz).
- **Mode 0:** MOSI is sampled on a detected SCLK rise; MISO changes on a detected SCLK fall. Bit order is MSB first.
- **FSM states:** IDLE, CMD, WR, RD.
  - **IDLE:** on SS_n fall, go to CMD. Load tx shift = reg[STATUS_ADDR] and drive bit7 on MISO immediately. Set busy=1 and spi_MISO_oe=1.
  - **CMD:** after the 8th rise, decode the command byte.
    - addr = cmd[7:3]; dir = cmd[1] (1 = write); cmd[2] and cmd[0] are ignored.
    - dir=1: go to WR.
    - dir=0: go to RD and load tx shift = reg[addr] in the same cycle. Bit7 of that byte appears at the next SCLK fall.
  - **WR:**
    - After every 8th rise, write reg[addr] = rx byte.
    - Pulse spi_wr_valid for 1 clk with the pre-increment addr and the data.
    - Then addr = addr+1, wrapping 31 to 0.
    - MISO shifts 0s during WR.
  - **RD:**
    - After every 8th rise, addr = addr+1 (wrapping) and tx shift = reg[new addr].
    - Register values are sampled at byte boundaries.
  - **Any state:** on SS_n rise, return to IDLE. A partial byte is discarded with no write and no pulse. busy=0 and spi_MISO_oe=0 one clk after the detected rise. The bit counter is cleared.
- **Bit counter:** 3-bit, reset at each SS_n fall and at each byte boundary.
- **Host port:**
  - host_wr writes reg[host_addr] on the same edge.
  - If an SPI write and a host write hit the same register in the same cycle, the SPI write wins.
  - host_rdata reflects the register contents as of the previous edge, including SPI writes.
- **Glitches:** SCLK edges while SS_n is high are ignored. An SS_n fall while not in IDLE cannot occur, because a rise must precede it.
- **Reset mid-transaction:** immediate return to IDLE with register contents reinitialised. The master must deassert SS_n before starting the next transaction.

Test Plan:
All SPI stimulus uses SCLK = clk/10.
1. Reset, then host_addr=5 -> host_rdata=00 after 1 clk; spi_MISO_oe=0; busy=0; no spi_wr_valid.
2. SS_n low, MOSI 0x2A,0xA5,0x3C, SS_n high:
   - spi_wr_valid pulses twice: (5,A5) then (6,3C).
   - host reads reg5=A5, reg6=3C.
   - MISO during cmd = reg0 = 00.
3. Host writes reg0=42 and reg31=81; SPI cmd 0xF8 plus 2 dummy bytes -> MISO bytes 42, 81, 42 (address wraps 31 to 0); no spi_wr_valid.
4. SPI cmd 0x12 (addr 2, write), then 4 bits of 0xFF, then SS_n high:
   - no spi_wr_valid; reg2 unchanged.
   - next transaction 0x12,0x77 writes reg2=77.
5. SPI write byte completes in the same clk as host_wr to addr 7 (SPI 0x55, host 0xAA) -> reg7=55.
6. Assert reset mid-byte during a read -> outputs 0 and registers 00 immediately. After release, SS_n cycle, then cmd 0x28 reads reg5 = 00.
